dumpoff_monitor: RTL and testbench
==================================

Name: dumpoff_monitor

Overview:
- Receiving end of the power-up dump-off pulse; sits beside the dump-off generator in the 2D NMR EC FPGA.
- After reset release, measures two things: the delay until dumpoff rises, and the high width of the pulse.
- Checks both against parameter windows and reports a sticky pass/fail with error code.
- Downstream pulse sequencing uses dump_ok to hold off the first excitation until the dump discharge is confirmed valid.

Parameters:
CW, 8, width of delay/width counters and measured outputs
DLY_MIN, 1, minimum legal delay count (inclusive)
DLY_MAX, 4, maximum legal delay count (inclusive)
WID_MIN, 17, minimum legal high-width count (inclusive)
WID_MAX, 21, maximum legal high-width count (inclusive)
TIMEOUT, 255, count at which waiting for a rise or fall is abandoned; must be <= 2^CW-1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset
dumpoff  input  1  dump-off pulse under test, synchronous to clk
done  output  1  measurement complete, sticky until reset
dump_ok  output  1  done and err==0
err  output  4  bit0 delay outside window; bit1 width outside window; bit2 timeout; bit3 extra rising edge after done
delay_meas  output  CW  latched cycles from reset release to first high sample
width_meas  output  CW  latched number of consecutive high samples

Behaviour:
- Reset (async, reset==0): state=WAIT_RISE; dly_cnt=0, wid_cnt=0, dump_d=0; done=0, dump_ok=0, err=0, delay_meas=0, width_meas=0.
- dump_d registers dumpoff every cycle. Rising edge in DONE is detected as dumpoff & ~dump_d.
- State WAIT_RISE, sampled dumpoff==0:
  - dly_cnt++.
  - If dly_cnt==TIMEOUT: err[2]<=1, delay_meas<=dly_cnt, done<=1, go DONE.
- State WAIT_RISE, sampled dumpoff==1:
  - delay_meas<=dly_cnt; err[0]<=(dly_cnt<DLY_MIN || dly_cnt>DLY_MAX).
  - wid_cnt<=1; go HIGH.
  - A pulse already high on the first cycle after reset gives delay_meas=0.
- State HIGH, sampled dumpoff==1:
  - wid_cnt++.
  - If wid_cnt==TIMEOUT: err[2]<=1, width_meas<=wid_cnt, done<=1, go DONE (stuck high).
- State HIGH, sampled dumpoff==0:
  - width_meas<=wid_cnt; err[1]<=(wid_cnt<WID_MIN || wid_cnt>WID_MAX).
  - done<=1; go DONE.
- State DONE:
  - Terminal until reset. Counters hold.
  - Any rising edge sets err[3]<=1 (sticky); no re-measurement.
- dump_ok is registered. It equals done && (err==0) using the next-state values, so it asserts in the same cycle as done.
- dump_ok drops one cycle after err[3] sets.
- Counters never wrap: TIMEOUT terminates counting before overflow.
- Timing, including a single-cycle pulse:
  - done asserts on the clock edge that samples the first low after the high run.
  - Latency from the falling edge of dumpoff is one clock.
  - A one-cycle pulse gives width_meas=1.
- Reset mid-measurement: all state and outputs clear immediately (async); measurement restarts from WAIT_RISE at the first edge after release.
- err bits outside the one being set at a given transition are never cleared except by reset.
- Illegal state encoding: recover to WAIT_RISE.

Test Plan:
- Nominal pulse: reset release, dumpoff low for 2 clk samples then high for 19 samples, then low → delay_meas=2, width_meas=19, err=0, done=1 and dump_ok=1 from clock 22.
- Short pulse: delay 2, high 5 samples → width_meas=5, err=4'b0010, done=1, dump_ok=0.
- No pulse: dumpoff held 0 → at sample 255, err=4'b0100, delay_meas=255, done=1, dump_ok=0.
- Stuck high: dumpoff already 1 at release and stays 1 → delay_meas=0, err[0]=1, then at width 255 err=4'b0101, done=1.
- Extra pulse: nominal pulse, then a second 3-cycle pulse 10 clocks later → err=4'b1000, dump_ok falls the cycle after that rise, width_meas stays 19.
- Reset mid-HIGH: assert reset at width 10 → all outputs 0 immediately; after release a nominal pulse gives delay_meas=2, width_meas=19, dump_ok=1.

Source files
------------

// File: rtl/dumpoff_monitor.sv
// dumpoff_monitor
//   Receiving end of the power-up dump-off pulse. After reset release it
//   measures the delay until dumpoff first rises and the high width of that
//   pulse, checks both against parameter windows, and reports a sticky
//   pass/fail result with an error code.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   dumpoff    in   dump-off pulse under test, synchronous to clk
//   done       out  measurement complete, sticky until reset
//   dump_ok    out  done with no error
//   err[3:0]   out  bit0 delay out of window, bit1 width out of window,
//                   bit2 timeout, bit3 extra rising edge after done
//   delay_meas out  cycles from reset release to first high sample
//   width_meas out  number of consecutive high samples
module dumpoff_monitor #(
  parameter int unsigned CW      = 8,
  parameter int unsigned DLY_MIN = 1,
  parameter int unsigned DLY_MAX = 4,
  parameter int unsigned WID_MIN = 17,
  parameter int unsigned WID_MAX = 21,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dumpoff,
  output logic          done,
  output logic          dump_ok,
  output logic [3:0]    err,
  output logic [CW-1:0] delay_meas,
  output logic [CW-1:0] width_meas
);

  localparam logic [CW-1:0] DMIN = CW'(DLY_MIN);
  localparam logic [CW-1:0] DMAX = CW'(DLY_MAX);
  localparam logic [CW-1:0] WMIN = CW'(WID_MIN);
  localparam logic [CW-1:0] WMAX = CW'(WID_MAX);
  localparam logic [CW-1:0] TOUT = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    HIGH      = 2'd1,
    DONE      = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] dly_cnt, dly_nxt, dly_inc;
  logic [CW-1:0] wid_cnt, wid_nxt, wid_inc;
  logic          dump_d;
  logic          done_nxt;
  logic          ok_nxt;
  logic [3:0]    err_nxt;
  logic [CW-1:0] delay_nxt, width_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= WAIT_RISE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dly_cnt    <= '0;
      wid_cnt    <= '0;
      dump_d     <= 1'b0;
      done       <= 1'b0;
      dump_ok    <= 1'b0;
      err        <= '0;
      delay_meas <= '0;
      width_meas <= '0;
    end else begin
      dly_cnt    <= dly_nxt;
      wid_cnt    <= wid_nxt;
      dump_d     <= dumpoff;
      done       <= done_nxt;
      dump_ok    <= ok_nxt;
      err        <= err_nxt;
      delay_meas <= delay_nxt;
      width_meas <= width_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dly_nxt   = dly_cnt;
    wid_nxt   = wid_cnt;
    done_nxt  = done;
    err_nxt   = err;
    delay_nxt = delay_meas;
    width_nxt = width_meas;
    dly_inc   = dly_cnt + 1'b1;
    wid_inc   = wid_cnt + 1'b1;

    // Timeout is tested on the incremented count so the terminating sample
    // is the TIMEOUT-th one and the counters never pass TIMEOUT.
    case (state)
      WAIT_RISE: begin
        if (dumpoff) begin
          delay_nxt  = dly_cnt;
          err_nxt[0] = (dly_cnt < DMIN) || (dly_cnt > DMAX);
          wid_nxt    = CW'(1);
          state_nxt  = HIGH;
        end else begin
          dly_nxt = dly_inc;
          if (dly_inc == TOUT) begin
            err_nxt[2] = 1'b1;
            delay_nxt  = dly_inc;
            done_nxt   = 1'b1;
            state_nxt  = DONE;
          end
        end
      end
      HIGH: begin
        if (dumpoff) begin
          wid_nxt = wid_inc;
          if (wid_inc == TOUT) begin
            err_nxt[2] = 1'b1;
            width_nxt  = wid_inc;
            done_nxt   = 1'b1;
            state_nxt  = DONE;
          end
        end else begin
          width_nxt  = wid_cnt;
          err_nxt[1] = (wid_cnt < WMIN) || (wid_cnt > WMAX);
          done_nxt   = 1'b1;
          state_nxt  = DONE;
        end
      end
      DONE: begin
        if (dumpoff && !dump_d) begin
          err_nxt[3] = 1'b1;
        end
      end
      default: begin
        state_nxt = WAIT_RISE;
      end
    endcase

    // Measurement errors gate dump_ok together with done, but an extra edge
    // after completion is taken from the registered err so dump_ok falls one
    // cycle after err[3] sets.
    ok_nxt = done_nxt && (err_nxt[2:0] == 3'b000) && !err[3];
  end

endmodule

// File: tb/tb_dumpoff_monitor.sv
module tb_dumpoff_monitor;

  localparam int unsigned CW      = 8;
  localparam int unsigned DLY_MIN = 1;
  localparam int unsigned DLY_MAX = 4;
  localparam int unsigned WID_MIN = 17;
  localparam int unsigned WID_MAX = 21;
  localparam int unsigned TIMEOUT = 255;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          dumpoff = 1'b0;
  logic          done, dump_ok;
  logic [3:0]    err;
  logic [CW-1:0] delay_meas, width_meas;

  int checks = 0;
  int errors = 0;
  int scen   = 0;
  int n      = 0;
  logic s [0:1023];

  dumpoff_monitor #(
    .CW(CW), .DLY_MIN(DLY_MIN), .DLY_MAX(DLY_MAX),
    .WID_MIN(WID_MIN), .WID_MAX(WID_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .dumpoff(dumpoff),
    .done(done), .dump_ok(dump_ok), .err(err),
    .delay_meas(delay_meas), .width_meas(width_meas)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s scen=%0d n=%0d actual=%0h required=%0h t=%0t", nm, scen, n, act, exp, $time);
    end
  endtask

  // Sample history since the last reset release: s[1] is the first sample.
  always @(posedge clk) begin
    if (!reset) n = 0;
    else begin
      n = n + 1;
      s[n] = dumpoff;
    end
  end

  // Expected outputs derived from the sample history alone.
  function automatic void model(output logic e_done, output logic e_ok,
                                output logic [3:0] e_err,
                                output logic [CW-1:0] e_dly, output logic [CW-1:0] e_wid);
    int k, len, fin, first3;
    e_done = 0; e_ok = 0; e_err = 0; e_dly = 0; e_wid = 0;
    fin = 0; first3 = 0; k = 0;
    if (n == 0) return;
    for (int i = 1; i <= n && i <= int'(TIMEOUT); i++) begin
      if (s[i]) begin k = i; break; end
    end
    if (k == 0) begin
      if (n >= int'(TIMEOUT)) begin
        e_done = 1; e_err[2] = 1; e_dly = CW'(TIMEOUT); fin = int'(TIMEOUT);
      end
    end else begin
      e_dly = CW'(k - 1);
      e_err[0] = ((k - 1) < int'(DLY_MIN)) || ((k - 1) > int'(DLY_MAX));
      len = 0;
      while (len < int'(TIMEOUT) && k + len <= n && s[k + len]) len++;
      if (len == int'(TIMEOUT)) begin
        e_done = 1; e_err[2] = 1; e_wid = CW'(TIMEOUT); fin = k + len - 1;
      end else if (k + len <= n) begin
        e_done = 1; e_wid = CW'(len); fin = k + len;
        e_err[1] = (len < int'(WID_MIN)) || (len > int'(WID_MAX));
      end
    end
    if (e_done) begin
      for (int j = fin + 1; j <= n; j++) begin
        if (s[j] && !s[j-1] && first3 == 0) first3 = j;
      end
      if (first3 != 0) e_err[3] = 1;
      e_ok = (e_err[2:0] == 3'b000) && (first3 == 0 || first3 == n);
    end
  endfunction

  always @(negedge clk) begin
    logic ed, eo;
    logic [3:0] ee;
    logic [CW-1:0] edl, ewd;
    if (!reset) begin
      ed = 0; eo = 0; ee = 0; edl = 0; ewd = 0;
    end else begin
      model(ed, eo, ee, edl, ewd);
    end
    chk("done", 32'(done), 32'(ed));
    chk("dump_ok", 32'(dump_ok), 32'(eo));
    chk("err", 32'(err), 32'(ee));
    chk("delay_meas", 32'(delay_meas), 32'(edl));
    chk("width_meas", 32'(width_meas), 32'(ewd));
    if (reset) begin
      if (scen == 1 && n == 21) chk("nom_done_early", 32'(done), 32'd0);
      if (scen == 1 && n == 22) chk("nom_done_c22", 32'({done, dump_ok}), 32'd3);
      if (scen == 3 && n == 254) chk("nop_done_early", 32'(done), 32'd0);
      if (scen == 3 && n == 255) chk("nop_done_255", 32'({done, delay_meas}), 32'h1ff);
      if (scen == 5 && n == 32) chk("extra_rise", 32'({dump_ok, err}), 32'h18);
      if (scen == 5 && n == 33) chk("extra_ok_drop", 32'({dump_ok, err}), 32'h08);
    end
  end

  task automatic drive(input logic v, input int cycles);
    dumpoff = v;
    repeat (cycles) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int sc, input logic d);
    scen    = sc;
    reset   = 1'b0;
    dumpoff = d;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_outputs", 32'({done, dump_ok, err, delay_meas, width_meas}), 32'd0);
    reset = 1'b1;
  endtask

  task automatic final_chk(input string nm, input logic ed, input logic eo,
                           input logic [3:0] ee, input logic [7:0] edl, input logic [7:0] ewd);
    chk({nm, "_done"}, 32'(done), 32'(ed));
    chk({nm, "_ok"}, 32'(dump_ok), 32'(eo));
    chk({nm, "_err"}, 32'(err), 32'(ee));
    chk({nm, "_delay"}, 32'(delay_meas), 32'(edl));
    chk({nm, "_width"}, 32'(width_meas), 32'(ewd));
  endtask

  initial begin
    // Nominal pulse
    do_reset(1, 1'b0);
    drive(0, 2); drive(1, 19); drive(0, 5);
    final_chk("nominal", 1, 1, 4'b0000, 8'd2, 8'd19);

    // Short pulse
    do_reset(2, 1'b0);
    drive(0, 2); drive(1, 5); drive(0, 3);
    final_chk("short", 1, 0, 4'b0010, 8'd2, 8'd5);

    // No pulse
    do_reset(3, 1'b0);
    drive(0, 260);
    final_chk("nopulse", 1, 0, 4'b0100, 8'd255, 8'd0);

    // Stuck high from release
    do_reset(4, 1'b1);
    drive(1, 260);
    final_chk("stuck", 1, 0, 4'b0101, 8'd0, 8'd255);

    // Extra pulse after completion
    do_reset(5, 1'b0);
    drive(0, 2); drive(1, 19); drive(0, 10); drive(1, 3); drive(0, 4);
    final_chk("extra", 1, 0, 4'b1000, 8'd2, 8'd19);

    // Reset in the middle of the high run
    do_reset(6, 1'b0);
    drive(0, 2); drive(1, 10);
    reset = 1'b0;
    #1;
    chk("midrst_async", 32'({done, dump_ok, err, delay_meas, width_meas}), 32'd0);
    do_reset(7, 1'b0);
    drive(0, 2); drive(1, 19); drive(0, 3);
    final_chk("after_midrst", 1, 1, 4'b0000, 8'd2, 8'd19);

    // One-cycle pulse
    do_reset(8, 1'b0);
    drive(0, 1); drive(1, 1); drive(0, 3);
    final_chk("onecycle", 1, 0, 4'b0010, 8'd1, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
